// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard control for a 5-stage MIPS-style core.
//               Produces PC/IF-ID/ID-EX stalls, IF-ID/ID-EX flushes, ALU
//               operand forwarding selects and a multicycle multu sequencer.
//               Build option: define HAZARD_FORWARD_EN to enable M/W operand
//               forwarding; otherwise any E/M dependency stalls D.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
    parameter int MUL_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] rsE,
    input  logic [4:0] rtE,
    input  logic [4:0] write_regE,
    input  logic [4:0] write_regM,
    input  logic [4:0] write_regW,
    input  logic       we_regE,
    input  logic       we_regM,
    input  logic       we_regW,
    input  logic       dm2regE,
    input  logic       dm2regM,
    input  logic       multu_enE,
    input  logic       branch_takenE,
    input  logic       jumpD,
    input  logic       jr_selD,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       flushD,
    output logic       flushE,
    output logic [1:0] fwd_aE,
    output logic [1:0] fwd_bE,
    output logic       mul_busy,
    output logic       mul_done
);

    localparam logic [0:0] c_S_IDLE   = 1'b0;
    localparam logic [0:0] c_S_BUSY   = 1'b1;
    localparam logic [2:0] c_CNT_LOAD = 3'(MUL_LAT - 2);

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_mul_done;
    logic       w_mul_stall;
    logic       w_load_use;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    // Multiplier sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Multiplier sequencer next state: IDLE -> BUSY on multu, count down to 0
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (multu_enE) begin
                    w_state_nxt = c_S_BUSY;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            c_S_BUSY: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // The first multu cycle is spent in IDLE, so the hold covers MUL_LAT-1
    // cycles and releases on the cycle that writes HI/LO.
    assign w_mul_done  = (r_state == c_S_BUSY) && (r_cnt == 3'd0);
    assign w_mul_stall = ((r_state == c_S_BUSY) && !w_mul_done) ||
                         ((r_state == c_S_IDLE) && multu_enE);

`ifdef HAZARD_FORWARD_EN
    // Select the youngest in-flight writer of src; r0 never forwards
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (src == 5'd0)                          return 2'b00;
        else if (we_regM && (write_regM == src))  return 2'b10;
        else if (we_regW && (write_regW == src))  return 2'b01;
        else                                      return 2'b00;
    endfunction

    assign w_fwd_a = fwd_sel(rsE);
    assign w_fwd_b = fwd_sel(rtE);

    // Only a load in E cannot be forwarded in time for the consumer in D
    assign w_load_use = dm2regE && we_regE && (write_regE != 5'd0) &&
                        ((write_regE == rsD) || (write_regE == rtD));

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, dm2regM};
`else
    // Without forwarding any pending E or M write to a D source must drain;
    // W is covered by the write-first register file.
    function automatic logic dep_hit(input logic [4:0] src);
        return (src != 5'd0) &&
               ((we_regE && (write_regE == src)) ||
                (we_regM && (write_regM == src)));
    endfunction

    assign w_fwd_a    = 2'b00;
    assign w_fwd_b    = 2'b00;
    assign w_load_use = dep_hit(rsD) || dep_hit(rtD);

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, dm2regE, dm2regM, rsE, rtE, write_regW, we_regW};
`endif

    // Output priority: reset, multicycle stall, branch flush, load-use, jump
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        fwd_aE   = 2'b00;
        fwd_bE   = 2'b00;
        mul_busy = 1'b0;
        mul_done = 1'b0;
        if (!rst) begin
            fwd_aE   = w_fwd_a;
            fwd_bE   = w_fwd_b;
            mul_busy = (r_state == c_S_BUSY);
            mul_done = w_mul_done;
            if (w_mul_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
            end else if (branch_takenE) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (w_load_use) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
            end else begin
                flushD = jumpD || jr_selD;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_unit
// Description : Self-checking bench for hazard_unit: directed scenarios with
//               literal expectations plus randomized traffic compared every
//               cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

    localparam int c_MUL_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, write_regE, write_regM, write_regW;
    logic       we_regE, we_regM, we_regW, dm2regE, dm2regM;
    logic       multu_enE, branch_takenE, jumpD, jr_selD;
    logic       stallF, stallD, stallE, flushD, flushE, mul_busy, mul_done;
    logic [1:0] fwd_aE, fwd_bE;

    int tests = 0;
    int fails = 0;
    int m_age = 0;   // cycles the current multu has already spent in E
    bit chk_en = 1'b0;

`ifdef HAZARD_FORWARD_EN
    localparam bit c_FWD = 1'b1;
`else
    localparam bit c_FWD = 1'b0;
`endif

    hazard_unit #(.MUL_LAT(c_MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .write_regE(write_regE), .write_regM(write_regM), .write_regW(write_regW),
        .we_regE(we_regE), .we_regM(we_regM), .we_regW(we_regW),
        .dm2regE(dm2regE), .dm2regM(dm2regM),
        .multu_enE(multu_enE), .branch_takenE(branch_takenE),
        .jumpD(jumpD), .jr_selD(jr_selD),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE),
        .fwd_aE(fwd_aE), .fwd_bE(fwd_bE),
        .mul_busy(mul_busy), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    // Model: multu occupancy as an elapsed-cycle count
    always @(posedge clk) begin
        if (rst)                     m_age <= 0;
        else if (m_age == 0)         m_age <= multu_enE ? 1 : 0;
        else if (m_age + 1 == c_MUL_LAT) m_age <= 0;
        else                         m_age <= m_age + 1;
    end

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (!c_FWD || src == 0)                return 2'd0;
        if (we_regM && write_regM == src)      return 2'd2;
        if (we_regW && write_regW == src)      return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit model_dep(input logic [4:0] src);
        if (src == 0) return 1'b0;
        if (c_FWD) return dm2regE && we_regE && write_regE == src;
        return (we_regE && write_regE == src) || (we_regM && write_regM == src);
    endfunction

    // Expected {stallF,stallD,stallE,flushD,flushE,fwd_aE,fwd_bE,mul_busy,mul_done}
    function automatic logic [10:0] model_out();
        bit busy, done, mstall, lu;
        bit sF, sD, sE, fD, fE;
        if (rst) return 11'd0;
        busy   = (m_age != 0);
        done   = busy && (m_age + 1 == c_MUL_LAT);
        mstall = busy ? !done : multu_enE;
        lu     = model_dep(rsD) || model_dep(rtD);
        sF = 0; sD = 0; sE = 0; fD = 0; fE = 0;
        if (mstall) begin
            sF = 1; sD = 1; sE = 1;
        end else if (branch_takenE) begin
            fD = 1; fE = 1;
        end else if (lu) begin
            sF = 1; sD = 1; fE = 1;
        end else begin
            fD = jumpD || jr_selD;
        end
        return {sF, sD, sE, fD, fE, model_fwd(rsE), model_fwd(rtE), busy, done};
    endfunction

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        logic [10:0] exp_v, act_v;
        if (chk_en) begin
            exp_v = model_out();
            act_v = {stallF, stallD, stallE, flushD, flushE, fwd_aE, fwd_bE, mul_busy, mul_done};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                $display("FAIL model_cmp t=%0t: got %b expected %b", $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        write_regE = 0; write_regM = 0; write_regW = 0;
        we_regE = 0; we_regM = 0; we_regW = 0; dm2regE = 0; dm2regM = 0;
        multu_enE = 0; branch_takenE = 0; jumpD = 0; jr_selD = 0;
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        dm2regE = 1; we_regE = 1; write_regE = 5'd8; rsD = 5'd8;
    endtask

    initial begin
        rst = 1;
        clear();
        step();
        chk_en = 1;
        step();
        #3;
        chk("reset_stall", {stallF, stallD, stallE}, 0);
        chk("reset_misc", {flushD, flushE, fwd_aE, fwd_bE, mul_busy, mul_done}, 0);

        // multu with MUL_LAT=4: three stall cycles then a done pulse
        step(); rst = 0; multu_enE = 1;
        for (int c = 1; c <= 4; c++) begin
            #3;
            chk($sformatf("mul_stallE_c%0d", c), stallE, (c < 4) ? 1 : 0);
            chk($sformatf("mul_done_c%0d", c), mul_done, (c == 4) ? 1 : 0);
            step();
        end
        multu_enE = 0;
        #3;
        chk("mul_after_busy", {mul_busy, mul_done, stallE}, 0);

        // Branch beats load-use
        step(); clear(); set_load_use(); branch_takenE = 1;
        #3;
        chk("br_lu_flush", {flushD, flushE}, 3);
        chk("br_lu_stall", {stallF, stallD}, 0);

        // Load-use stall then W forwarding
        step(); branch_takenE = 0;
        #3;
        chk("lu_stall", {stallF, stallD, flushE}, 7);
        step(); clear(); we_regW = 1; write_regW = 5'd8; rsE = 5'd8; rsD = 5'd8;
        #3;
        chk("lu_next_fwd", fwd_aE, c_FWD ? 1 : 0);
        chk("lu_next_nostall", {stallF, stallD}, 0);

        // M beats W; r0 never forwards
        step(); clear(); we_regM = 1; we_regW = 1; write_regM = 5; write_regW = 5; rsE = 5; rtE = 5;
        #3;
        chk("fwd_m_prio", {fwd_aE, fwd_bE}, c_FWD ? 4'b1010 : 0);
        step(); write_regM = 0; write_regW = 0; rsE = 0; rtE = 0;
        #3;
        chk("fwd_r0", {fwd_aE, fwd_bE}, 0);

        // Jump suppressed under stall, honoured once stall clears
        step(); clear(); set_load_use(); jumpD = 1;
        #3;
        chk("jump_under_stall", {flushD, stallD}, 1);
        step(); clear(); jumpD = 1;
        #3;
        chk("jump_no_stall", flushD, 1);

        // Reset in the second BUSY cycle aborts the multu
        step(); clear(); multu_enE = 1;
        step();
        step(); rst = 1;
        #3;
        chk("rst_mid_outs", {stallF, stallD, stallE, flushD, flushE, mul_busy, mul_done}, 0);
        step(); rst = 0; multu_enE = 0;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("rst_mid_idle%0d", c), {mul_busy, mul_done}, 0);
            step();
        end

        // Randomized traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 59) == 0);
            rsD           = 5'($urandom_range(0, 3));
            rtD           = 5'($urandom_range(0, 3));
            rsE           = 5'($urandom_range(0, 3));
            rtE           = 5'($urandom_range(0, 3));
            write_regE    = 5'($urandom_range(0, 3));
            write_regM    = 5'($urandom_range(0, 3));
            write_regW    = 5'($urandom_range(0, 3));
            we_regE       = 1'($urandom);
            we_regM       = 1'($urandom);
            we_regW       = 1'($urandom);
            dm2regE       = 1'($urandom);
            dm2regM       = 1'($urandom);
            multu_enE     = ($urandom_range(0, 5) == 0);
            branch_takenE = ($urandom_range(0, 4) == 0);
            jumpD         = ($urandom_range(0, 3) == 0);
            jr_selD       = ($urandom_range(0, 5) == 0);
            step();
        end

        @(posedge clk);
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
